// File: rtl/kernel_ctrl_pkg.sv
// Shared definitions for the kernel blend controller and the kernel converter:
// FSM states, kernel codes and port-width helpers.
package kernel_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        SETTLE,
        HANDSHAKE
    } ctrlState_t;

    localparam int KERNEL_EDGE = 0;
    localparam int KERNEL_BLUR = 1;

    // k_index spans 0..kRange inclusive, so one extra bit beyond $clog2.
    function automatic int kIndexWidth(input int kRange);
        return $clog2(kRange) + 1;
    endfunction

    function automatic int selWidth(input int numKernels);
        return (numKernels > 1) ? $clog2(numKernels) : 1;
    endfunction

endpackage

// File: rtl/sweep_sequencer.sv
// Auto-sweep source: counts frames while enabled and emits one triangle-wave
// step every SWEEP_FRAMES frames, bouncing off 0 and K_RANGE.
module sweep_sequencer
    import kernel_ctrl_pkg::*;
#(
    parameter int K_RANGE      = 8,
    parameter int SWEEP_FRAMES = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_frameStart,
    input  logic                            i_autoEn,
    input  logic [kIndexWidth(K_RANGE)-1:0] i_tgtIndex,
    output logic                            o_stepUp,
    output logic                            o_stepDown
);

    localparam int KW = kIndexWidth(K_RANGE);
    localparam int CW = $clog2(SWEEP_FRAMES + 1);
    localparam logic [KW-1:0] K_MAX      = KW'(K_RANGE);
    localparam logic [CW-1:0] COUNT_LAST = CW'(SWEEP_FRAMES - 1);

    logic [CW-1:0] r_count;
    logic          r_dirUp;
    logic          w_hit;

    assign w_hit = i_autoEn && i_frameStart && (r_count == COUNT_LAST);

    // The flip happens on the step that would otherwise saturate, so every step moves.
    assign o_stepUp   = w_hit && (r_dirUp ? (i_tgtIndex != K_MAX) : (i_tgtIndex == '0));
    assign o_stepDown = w_hit && !o_stepUp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_dirUp <= 1'b1;
        end else begin
            if (!i_autoEn) begin
                r_count <= '0;
            end else if (i_frameStart) begin
                r_count <= (r_count == COUNT_LAST) ? '0 : r_count + CW'(1);
            end
            if (w_hit) begin
                r_dirUp <= o_stepUp;
            end
        end
    end

endmodule

// File: rtl/kernel_blend_controller.sv
// Collects blend-index and kernel-select requests, commits them only at frame
// boundaries, and hands each committed configuration to the convolution core.
module kernel_blend_controller
    import kernel_ctrl_pkg::*;
#(
    parameter int K_RANGE      = 8,
    parameter int NUM_KERNELS  = 2,
    parameter int SWEEP_FRAMES = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              frame_start,
    input  logic                              step_up,
    input  logic                              step_down,
    input  logic                              sel_req,
    input  logic [selWidth(NUM_KERNELS)-1:0]  sel_code,
    input  logic                              auto_en,
    input  logic                              cfg_ready,
    output logic [kIndexWidth(K_RANGE)-1:0]   k_index,
    output logic [selWidth(NUM_KERNELS)-1:0]  kernel_sel,
    output logic                              cfg_valid,
    output logic                              pending
);

    localparam int KW  = kIndexWidth(K_RANGE);
    localparam int SW  = selWidth(NUM_KERNELS);
    localparam int SW1 = SW + 1;
    localparam logic [KW-1:0] K_MAX     = KW'(K_RANGE);
    localparam logic [SW:0]   SEL_LIMIT = SW1'(NUM_KERNELS);

    ctrlState_t    r_state, w_stateNext;
    logic [KW-1:0] r_tgtIndex, w_nextIdx, r_kIndex;
    logic [SW-1:0] r_tgtSel, w_nextSel, r_kernelSel;
    logic          r_dirty, w_nextDirty, r_cfgValid;
    logic          w_sweepUp, w_sweepDown, w_reqUp, w_reqDown, w_selValid;
    logic          w_commit, w_setValid, w_clrValid;

    sweep_sequencer #(
        .K_RANGE      (K_RANGE),
        .SWEEP_FRAMES (SWEEP_FRAMES)
    ) u_sweep (
        .clk          (clk),
        .reset        (reset),
        .i_frameStart (frame_start),
        .i_autoEn     (auto_en),
        .i_tgtIndex   (r_tgtIndex),
        .o_stepUp     (w_sweepUp),
        .o_stepDown   (w_sweepDown)
    );

    // While sweeping, the sequencer owns the index; user steps are dropped.
    assign w_reqUp    = auto_en ? w_sweepUp   : step_up;
    assign w_reqDown  = auto_en ? w_sweepDown : step_down;
    assign w_selValid = sel_req && ({1'b0, sel_code} < SEL_LIMIT) && (sel_code != r_tgtSel);

    always_comb begin
        w_nextIdx   = r_tgtIndex;
        w_nextSel   = r_tgtSel;
        w_nextDirty = r_dirty;
        if (w_selValid) begin
            w_nextSel   = sel_code;
            w_nextIdx   = '0;
            w_nextDirty = 1'b1;
        end else if (w_reqUp && !w_reqDown && (r_tgtIndex != K_MAX)) begin
            w_nextIdx   = r_tgtIndex + KW'(1);
            w_nextDirty = 1'b1;
        end else if (w_reqDown && !w_reqUp && (r_tgtIndex != '0)) begin
            w_nextIdx   = r_tgtIndex - KW'(1);
            w_nextDirty = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A request arriving with frame_start counts toward that same frame's commit.
    always_comb begin
        w_stateNext = r_state;
        w_commit    = 1'b0;
        w_setValid  = 1'b0;
        w_clrValid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (frame_start && w_nextDirty) begin
                    w_stateNext = COMMIT;
                end
            end
            COMMIT: begin
                w_commit    = 1'b1;
                w_stateNext = SETTLE;
            end
            SETTLE: begin
                w_setValid  = 1'b1;
                w_stateNext = HANDSHAKE;
            end
            HANDSHAKE: begin
                if (r_cfgValid && cfg_ready) begin
                    w_clrValid  = 1'b1;
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Commit takes this cycle's target so a request landing on the COMMIT cycle is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tgtIndex  <= '0;
            r_tgtSel    <= SW'(KERNEL_EDGE);
            r_dirty     <= 1'b0;
            r_kIndex    <= '0;
            r_kernelSel <= SW'(KERNEL_EDGE);
            r_cfgValid  <= 1'b0;
        end else begin
            r_tgtIndex <= w_nextIdx;
            r_tgtSel   <= w_nextSel;
            r_dirty    <= w_commit ? 1'b0 : w_nextDirty;
            if (w_commit) begin
                r_kIndex    <= w_nextIdx;
                r_kernelSel <= w_nextSel;
            end
            if (w_setValid) begin
                r_cfgValid <= 1'b1;
            end else if (w_clrValid) begin
                r_cfgValid <= 1'b0;
            end
        end
    end

    assign k_index    = r_kIndex;
    assign kernel_sel = r_kernelSel;
    assign cfg_valid  = r_cfgValid;
    assign pending    = r_dirty;

endmodule
